// File: rtl/spiflash_pkg.sv
// Shared constants and FSM encoding for the SPI-flash
// instruction cache.
package spiflash_pkg;

  localparam int FLASH_AW = 24;
  localparam int FLASH_DW = 32;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spiflash_icache_if.sv
// CPU-side read bus and flash-side fill bus of the
// instruction cache, bundled with the flush request.
interface spiflash_icache_if;
  import spiflash_pkg::*;

  logic                mem_valid;
  logic                mem_ready;
  logic [FLASH_AW-1:0] mem_addr;
  logic [FLASH_DW-1:0] mem_rdata;
  logic                flush;
  logic                flash_valid;
  logic                flash_ready;
  logic [FLASH_AW-1:0] flash_addr;
  logic [FLASH_DW-1:0] flash_rdata;

  modport slave (
    input  mem_valid, mem_addr, flush,
    input  flash_ready, flash_rdata,
    output mem_ready, mem_rdata,
    output flash_valid, flash_addr
  );

  modport master (
    output mem_valid, mem_addr, flush,
    output flash_ready, flash_rdata,
    input  mem_ready, mem_rdata,
    input  flash_valid, flash_addr
  );

endinterface

// File: rtl/spiflash_icache_store.sv
// Direct-mapped line storage: valid bits with async reset,
// tag/data arrays without reset.
module spiflash_icache_store
  import spiflash_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IW    = $clog2(LINES),
  parameter int TW    = FLASH_AW - IW - 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [IW-1:0]       rd_idx,
  output logic                rd_valid,
  output logic [TW-1:0]       rd_tag,
  output logic [FLASH_DW-1:0] rd_data,
  input  logic                we,
  input  logic [IW-1:0]       wr_idx,
  input  logic [TW-1:0]       wr_tag,
  input  logic [FLASH_DW-1:0] wr_data,
  input  logic                wr_valid,
  input  logic                flush
);

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TW-1:0]       tag_q  [LINES];
  logic [FLASH_DW-1:0] data_q [LINES];

  // flush wins over a same-cycle fill
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[wr_idx] = wr_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/spiflash_icache.sv
// One-word-per-line direct-mapped read cache in front of
// a SPI flash controller, with saturating hit/miss counters.
module spiflash_icache
  import spiflash_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  spiflash_icache_if.slave      bus,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);

  localparam int IW = $clog2(LINES);
  localparam int TW = FLASH_AW - IW - 2;

  logic [IW-1:0]       idx;
  logic [TW-1:0]       tag;
  logic                rd_valid;
  logic [TW-1:0]       rd_tag;
  logic [FLASH_DW-1:0] rd_data;
  logic                we;
  logic                hit;
  logic [1:0]          unused_addr_lo;

  state_e              state_q, state_d;
  logic                mem_ready_q, mem_ready_d;
  logic [FLASH_DW-1:0] rdata_q, rdata_d;
  logic                fvalid_q, fvalid_d;
  logic [FLASH_AW-1:0] faddr_q, faddr_d;
  logic [CNT_W-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    miss_q, miss_d;
  logic                flushed_q, flushed_d;

  assign idx = bus.mem_addr[IW+1:2];
  assign tag = bus.mem_addr[FLASH_AW-1:IW+2];
  assign unused_addr_lo = bus.mem_addr[1:0];
  assign hit = rd_valid && (rd_tag == tag);

  spiflash_icache_store #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW)
  ) u_store (
    .clk      (clk),
    .resetn   (resetn),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (we),
    .wr_idx   (faddr_q[IW+1:2]),
    .wr_tag   (faddr_q[FLASH_AW-1:IW+2]),
    .wr_data  (bus.flash_rdata),
    .wr_valid (!flushed_q),
    .flush    (bus.flush)
  );

  always_comb begin
    state_d     = state_q;
    mem_ready_d = 1'b0;
    rdata_d     = rdata_q;
    fvalid_d    = fvalid_q;
    faddr_d     = faddr_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    flushed_d   = flushed_q;
    we          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          if (hit) begin
            rdata_d     = rd_data;
            hit_d       = sat_inc(hit_q);
            mem_ready_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            miss_d    = sat_inc(miss_q);
            faddr_d   = {bus.mem_addr[FLASH_AW-1:2], 2'b00};
            fvalid_d  = 1'b1;
            flushed_d = 1'b0;
            state_d   = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        // a flush seen while filling keeps the new line invalid
        if (bus.flush) begin
          flushed_d = 1'b1;
        end
        if (bus.flash_ready) begin
          we          = 1'b1;
          rdata_d     = bus.flash_rdata;
          fvalid_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mem_ready_q <= 1'b0;
      rdata_q     <= '0;
      fvalid_q    <= 1'b0;
      faddr_q     <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      rdata_q     <= rdata_d;
      fvalid_q    <= fvalid_d;
      faddr_q     <= faddr_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      flushed_q   <= flushed_d;
    end
  end

  assign bus.mem_ready   = mem_ready_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.flash_valid = fvalid_q;
  assign bus.flash_addr  = faddr_q;
  assign hit_cnt         = hit_q;
  assign miss_cnt        = miss_q;

endmodule

// File: tb/tb_spiflash_icache.sv
// Randomized read/flush/reset bench for spiflash_icache
// against a line-level reference model.
module tb_spiflash_icache;

  localparam int LINES = 16;
  localparam int IW    = 4;

  logic clk;
  logic resetn;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  spiflash_icache_if bus ();

  spiflash_icache #(
    .LINES (LINES)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  int          flash_delay = 0;
  int          bursts = 0;
  int          addr_err = 0;
  int          ready_err = 0;
  logic [23:0] burst_addr = '0;
  logic [31:0] seed;

  bit          mv [LINES];
  int          mt [LINES];
  logic [15:0] hit_m;
  logic [15:0] miss_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    logic [31:0] w;
    w = {8'd0, a[23:2], 2'b00};
    if (w == 32'h100) return 32'hDEADBEEF;
    return (w * 32'h9E3779B1) ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endtask

  // flash controller: answers after flash_delay extra cycles
  initial begin
    int fcnt;
    fcnt = 0;
    bus.flash_ready = 1'b0;
    bus.flash_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.flash_ready) begin
        bus.flash_ready = 1'b0;
      end else if (bus.flash_valid && resetn) begin
        if (fcnt >= flash_delay) begin
          bus.flash_ready = 1'b1;
          bus.flash_rdata = flash_word(bus.flash_addr);
          fcnt = 0;
        end else begin
          fcnt++;
        end
      end else begin
        fcnt = 0;
      end
    end
  end

  // burst counter, flash_addr stability, one-cycle ready
  initial begin
    logic pf, pr;
    pf = 1'b0;
    pr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.flash_valid && !pf) begin
        bursts++;
        burst_addr = bus.flash_addr;
        if (bus.flash_addr[1:0] != 2'b00) addr_err++;
      end
      if (bus.flash_valid && pf && bus.flash_addr != burst_addr)
        addr_err++;
      if (bus.mem_ready && pr) ready_err++;
      pf = bus.flash_valid;
      pr = bus.mem_ready;
    end
  end

  // flush_at: -1 none, 0 with the request, 1 one cycle later
  task automatic do_read(input logic [23:0] a, input int dly,
                         input int flush_at);
    int          idx, tg, n, b0, lat;
    bit          hit, r;
    logic [31:0] d;
    idx = int'(a[IW+1:2]);
    tg  = int'(a >> (IW + 2));
    hit = mv[idx] && (mt[idx] == tg);
    flash_delay = dly;
    b0 = bursts;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.flush     = (flush_at == 0);
    n = 0;
    r = 1'b0;
    d = '0;
    while (!r && n < 200) begin
      @(negedge clk);
      r = bus.mem_ready;
      d = bus.mem_rdata;
      @(posedge clk);
      n++;
      #1;
      bus.flush = (flush_at == n);
      if (r) bus.mem_valid = 1'b0;
    end
    bus.mem_valid = 1'b0;
    bus.flush = 1'b0;
    lat = hit ? 2 : dly + 3;
    if (hit) hit_m = sat(hit_m);
    else miss_m = sat(miss_m);
    if (flush_at >= 0) model_clear();
    if (!hit && flush_at < 1) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
    chk("ready", 32'(r), 32'd1);
    chk("rdata", d, flash_word(a));
    chk("latency", n, lat);
    chk("fills", bursts - b0, hit ? 0 : 1);
    if (!hit)
      chk("flash_addr", 32'(burst_addr), 32'({a[23:2], 2'b00}));
    chk("hit_cnt", 32'(hit_cnt), 32'(hit_m));
    chk("miss_cnt", 32'(miss_cnt), 32'(miss_m));
  endtask

  task automatic pulse_flush();
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [23:0] a;
    int          fa, rr;
    seed          = $urandom;
    resetn        = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.flush     = 1'b0;
    model_clear();
    for (int i = 0; i < LINES; i++) mt[i] = 0;
    hit_m  = '0;
    miss_m = '0;

    #3;
    chk("rst_ready", 32'(bus.mem_ready), 0);
    chk("rst_rdata", bus.mem_rdata, 0);
    chk("rst_fvalid", 32'(bus.flash_valid), 0);
    chk("rst_faddr", 32'(bus.flash_addr), 0);
    chk("rst_hit", 32'(hit_cnt), 0);
    chk("rst_miss", 32'(miss_cnt), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    do_read(24'h000100, 5, -1);
    do_read(24'h000100, 0, -1);
    do_read(24'h000140, 2, -1);
    do_read(24'h000100, 1, -1);
    chk("aliased_misses", 32'(miss_cnt), 3);

    for (int k = 0; k < 40; k++) begin
      a = 24'h000400 | 24'($urandom_range(0, 3) << 6)
        | 24'($urandom_range(0, 15) << 2) | 24'($urandom_range(0, 3));
      rr = $urandom_range(0, 9);
      fa = (rr == 0) ? 0 : (rr == 1) ? 1 : -1;
      do_read(a, $urandom_range(0, 3), fa);
    end

    do_read(24'h000200, 4, 1);
    do_read(24'h000200, 0, -1);
    do_read(24'h000200, 0, 0);
    do_read(24'h000200, 3, -1);
    pulse_flush();
    do_read(24'h000200, 1, -1);

    pulse_flush();
    flash_delay = 20;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 24'h000200;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fill_pending", 32'(bus.flash_valid), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_fvalid", 32'(bus.flash_valid), 0);
    chk("rst_mid_ready", 32'(bus.mem_ready), 0);
    chk("rst_mid_hit", 32'(hit_cnt), 0);
    chk("rst_mid_miss", 32'(miss_cnt), 0);
    bus.mem_valid = 1'b0;
    model_clear();
    hit_m  = '0;
    miss_m = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    do_read(24'h000200, 2, -1);

    force dut.hit_q = 16'hFFFD;
    @(negedge clk);
    release dut.hit_q;
    hit_m = 16'hFFFD;
    do_read(24'h000200, 0, -1);
    do_read(24'h000200, 0, -1);
    do_read(24'h000200, 0, -1);
    chk("hit_sat", 32'(hit_cnt), 32'hFFFF);

    chk("ready_pulse", ready_err, 0);
    chk("burst_addr", addr_err, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spiflash_icache.md
SPIFLASH_ICACHE -- requirements
Module: spiflash_icache

Interface
REQ-001 Parameter: LINES, default 16, number of direct-mapped one-word lines; power of two, 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 mem_valid  input  1  CPU read request, held until mem_ready.
REQ-005 mem_ready  output  1  one-cycle completion pulse to CPU.
REQ-006 mem_addr  input  24  CPU byte address; bits [1:0] ignored.
REQ-007 mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-008 flush  input  1  invalidate all lines (level; sampled each cycle).
REQ-009 flash_valid  output  1  fill request to downstream flash controller.
REQ-010 flash_ready  input  1  fill completion from flash controller.
REQ-011 flash_addr  output  24  fill word address, bits [1:0]=0.
REQ-012 flash_rdata  input  32  fill data, valid when flash_ready=1.
REQ-013 hit_cnt  output  16  saturating hit counter.
REQ-014 miss_cnt  output  16  saturating miss counter.

Function
REQ-015 Address split: index = mem_addr[IW+1:2], IW=log2(LINES); tag = mem_addr[23:IW+2].
REQ-016 Storage per line: valid bit, tag, 32-bit data word.
REQ-017 FSM states: IDLE, FILL, RESP.
REQ-018 IDLE: mem_valid and line valid with matching tag -> hit; capture data into mem_rdata, hit_cnt+1, go to RESP.
REQ-019 IDLE: mem_valid and miss -> miss_cnt+1, latch word address, go to FILL.
REQ-020 FILL: flash_valid=1 and flash_addr held constant until flash_ready=1.
REQ-021 FILL with flash_ready=1: write data/tag/valid to the line, load mem_rdata from flash_rdata, drop flash_valid, go to RESP.
REQ-022 RESP: mem_ready=1 for exactly one cycle, then IDLE; the next request is accepted no earlier than the cycle after RESP.
REQ-023 Hit latency: mem_ready asserts 2 cycles after mem_valid rises. Miss latency: 2 cycles plus the flash_ready wait.
REQ-024 mem_valid dropping during FILL does not abort the fill; the line is still written and RESP is still issued.
REQ-025 flush in IDLE or RESP: all valid bits clear on the next edge.
REQ-026 flush in IDLE together with mem_valid: the lookup sees pre-flush state; the flush still takes effect.
REQ-027 flush during FILL: all valid bits clear; the completing fill writes data but leaves that line invalid; mem_rdata is still correct.
REQ-028 Counters saturate at 16'hFFFF; flush does not clear them.
REQ-029 flash_valid is never asserted outside FILL.

Reset
REQ-030 Reset forces state IDLE; mem_ready=0, mem_rdata=0, flash_valid=0, flash_addr=0, hit_cnt=0, miss_cnt=0, and all valid bits=0.
REQ-031 Tag and data arrays need no reset.
REQ-032 Reset asserted mid-FILL drops flash_valid immediately (asynchronously); no line is written.

Structure
REQ-033 Shared package spiflash_pkg holds FLASH_AW=24, FLASH_DW=32, and the FSM state encoding.
REQ-034 Tag/data/valid storage lives in sub-module spiflash_icache_store, with one read port, one write port, and a flush clear.

Verification
REQ-035 Cold read at 0x000100, flash returns 0xDEADBEEF after 5 cycles -> one flash_valid burst with addr 0x000100; mem_rdata=0xDEADBEEF; miss_cnt=1.
REQ-036 Repeat read at 0x000100 -> mem_ready 2 cycles after mem_valid; flash_valid stays 0; hit_cnt=1.
REQ-037 LINES=16: read 0x000100, then 0x000140 (same index, different tag), then 0x000100 -> three fills; miss_cnt=3.
REQ-038 Pulse flush for 1 cycle during a FILL for 0x000200 -> data returned correctly; a re-read of 0x000200 misses again.
REQ-039 Assert reset mid-FILL -> flash_valid=0 within the same cycle; after release, reading 0x000200 misses.
REQ-040 Force hit_cnt to 0xFFFF via 65535 hits, then one more hit -> hit_cnt stays at 0xFFFF.
